// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared encodings for the RV32I multi-cycle control unit
package rv_ctrl_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;
  localparam logic [1:0] WD_IMM = 2'b11;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  // Ungated control word produced by the decoder for the current IR.
  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_in1;
    logic       alu_in2;
    logic [2:0] imm_op;
    logic       regs_r;
    logic [1:0] w_data;
    logic       is_branch;
    logic       branch_zero;
    logic       is_jump;
    logic       is_load;
    logic       is_store;
    logic       is_muldiv;
    logic [3:0] lane_mask;
  } ctrl_t;

  // funct3[1:0] access size to byte-lane enables: byte, half, word.
  function automatic logic [3:0] size_to_lanes(input logic [1:0] size);
    case (size)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/rv_decode_core.sv
// rtl/rv_decode_core.sv - combinational opcode/funct to control word decoder
module rv_decode_core import rv_ctrl_pkg::*; #(
  parameter int ENABLE_M = 0
) (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       funct7_m,
  output ctrl_t      ctrl,
  output logic       illegal
);

  // Map the instruction fields to a control word; unknown encodings flag illegal.
  always_comb begin
    ctrl           = '0;
    ctrl.alu_op    = ALU_ADD;
    ctrl.lane_mask = size_to_lanes(funct3[1:0]);
    illegal        = 1'b0;
    case (opcode)
      OP_LUI: begin
        ctrl.imm_op = IMM_U;
        ctrl.w_data = WD_IMM;
      end
      OP_AUIPC: begin
        ctrl.alu_in1 = 1'b1;
        ctrl.alu_in2 = 1'b1;
        ctrl.imm_op  = IMM_U;
        ctrl.w_data  = WD_ALU;
      end
      OP_JAL: begin
        ctrl.alu_in1 = 1'b1;
        ctrl.alu_in2 = 1'b1;
        ctrl.imm_op  = IMM_J;
        ctrl.w_data  = WD_PC4;
        ctrl.is_jump = 1'b1;
      end
      OP_JALR: begin
        ctrl.alu_in2 = 1'b1;
        ctrl.imm_op  = IMM_I;
        ctrl.regs_r  = 1'b1;
        ctrl.w_data  = WD_PC4;
        ctrl.is_jump = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.imm_op    = IMM_B;
        ctrl.regs_r    = 1'b1;
        ctrl.is_branch = 1'b1;
        if (funct3[1])      ctrl.alu_op = ALU_SLTU;
        else if (funct3[2]) ctrl.alu_op = ALU_SLT;
        else                ctrl.alu_op = ALU_XOR;
        ctrl.branch_zero = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
      end
      OP_LOAD: begin
        ctrl.alu_in2 = 1'b1;
        ctrl.imm_op  = IMM_I;
        ctrl.regs_r  = 1'b1;
        ctrl.w_data  = WD_MEM;
        ctrl.is_load = 1'b1;
      end
      OP_STORE: begin
        ctrl.alu_in2  = 1'b1;
        ctrl.imm_op   = IMM_S;
        ctrl.regs_r   = 1'b1;
        ctrl.is_store = 1'b1;
      end
      OP_IMM: begin
        ctrl.alu_in2 = 1'b1;
        ctrl.imm_op  = IMM_I;
        ctrl.regs_r  = 1'b1;
        // Only shifts carry a meaningful IR[30]; elsewhere it is immediate data.
        ctrl.alu_op  = (funct3[1:0] == 2'b01) ? {funct7, funct3} : {1'b0, funct3};
      end
      OP_REG: begin
        ctrl.regs_r = 1'b1;
        if (funct7_m) begin
          if (ENABLE_M != 0) ctrl.is_muldiv = 1'b1;
          else               illegal = 1'b1;
        end else begin
          ctrl.alu_op = {funct7, funct3};
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - RV32I multi-cycle control FSM with mul/div handshake
module multicycle_control_unit import rv_ctrl_pkg::*; #(
  parameter int ENABLE_M    = 0,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       funct7_m,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  input  logic       muldiv_done,
  output logic       imem_req,
  output logic       ir_write,
  output logic       pc_write,
  output logic [3:0] alu_op,
  output logic       alu_in1,
  output logic       alu_in2,
  output logic [2:0] imm_op,
  output logic       regs_r_enb,
  output logic       regs_w_enb,
  output logic [1:0] regs_w_data,
  output logic       muldiv_sel,
  output logic       muldiv_start,
  output logic [3:0] mem_r_enb,
  output logic [3:0] mem_w_enb,
  output logic       branch,
  output logic       branch_zero,
  output logic       jump,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [2:0] state
);

  // Last counter value seen in MEM before a missing ack becomes a bus error.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           cur;
  state_t           nxt;
  ctrl_t            ctrl;
  logic             illegal;
  logic [CNT_W-1:0] cnt;
  logic             md_started;
  logic             trap_q;
  logic [1:0]       cause_q;
  logic [1:0]       set_cause;

  rv_decode_core #(.ENABLE_M(ENABLE_M)) u_decode (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7   (funct7),
    .funct7_m (funct7_m),
    .ctrl     (ctrl),
    .illegal  (illegal)
  );

  // State, MEM wait counter, mul/div start flag and sticky trap registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur        <= S_FETCH;
      cnt        <= '0;
      md_started <= 1'b0;
      trap_q     <= 1'b0;
      cause_q    <= CAUSE_NONE;
    end else begin
      cur        <= nxt;
      cnt        <= (cur == S_MEM && nxt == S_MEM) ? cnt + CNT_W'(1) : '0;
      md_started <= (cur == S_EXEC) && (nxt == S_EXEC) && ctrl.is_muldiv;
      if (set_cause != CAUSE_NONE) begin
        trap_q  <= 1'b1;
        cause_q <= set_cause;
      end
    end
  end

  // Next-state logic and state-gated control outputs.
  always_comb begin
    nxt          = cur;
    set_cause    = CAUSE_NONE;
    imem_req     = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    alu_op       = ALU_ADD;
    alu_in1      = 1'b0;
    alu_in2      = 1'b0;
    imm_op       = IMM_NONE;
    regs_r_enb   = 1'b0;
    regs_w_enb   = 1'b0;
    regs_w_data  = WD_ALU;
    muldiv_sel   = 1'b0;
    muldiv_start = 1'b0;
    mem_r_enb    = 4'b0000;
    mem_w_enb    = 4'b0000;
    branch       = 1'b0;
    branch_zero  = 1'b0;
    jump         = 1'b0;
    case (cur)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_write = 1'b1;
          nxt      = S_DECODE;
        end
      end
      S_DECODE: begin
        if (illegal) begin
          nxt       = S_TRAP;
          set_cause = CAUSE_ILLEGAL;
        end else begin
          regs_r_enb = ctrl.regs_r;
          nxt        = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op      = ctrl.alu_op;
        alu_in1     = ctrl.alu_in1;
        alu_in2     = ctrl.alu_in2;
        imm_op      = ctrl.imm_op;
        branch      = ctrl.is_branch;
        branch_zero = ctrl.branch_zero;
        jump        = ctrl.is_jump;
        if (ctrl.is_branch) begin
          pc_write = 1'b1;
          nxt      = S_FETCH;
        end else if (ctrl.is_load || ctrl.is_store) begin
          nxt = S_MEM;
        end else if (ctrl.is_muldiv) begin
          muldiv_start = !md_started;
          if (muldiv_done) nxt = S_WB;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        mem_r_enb = ctrl.is_load  ? ctrl.lane_mask : 4'b0000;
        mem_w_enb = ctrl.is_store ? ctrl.lane_mask : 4'b0000;
        // The ack is checked first so a late ack on the final cycle still completes.
        if (dmem_ack) begin
          if (ctrl.is_store) begin
            pc_write = 1'b1;
            nxt      = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end else if (cnt == CNT_LAST) begin
          nxt       = S_TRAP;
          set_cause = CAUSE_TIMEOUT;
        end
      end
      S_WB: begin
        regs_w_enb  = 1'b1;
        regs_w_data = ctrl.w_data;
        muldiv_sel  = ctrl.is_muldiv;
        pc_write    = 1'b1;
        jump        = ctrl.is_jump;
        nxt         = S_FETCH;
      end
      S_TRAP:  nxt = S_TRAP;
      default: nxt = S_FETCH;
    endcase
  end

  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign state      = cur;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - directed self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7, funct7_m, imem_ack, dmem_ack, muldiv_done;

  logic       imem_req, ir_write, pc_write, alu_in1, alu_in2;
  logic [3:0] alu_op, mem_r_enb, mem_w_enb;
  logic [2:0] imm_op, state;
  logic       regs_r_enb, regs_w_enb, muldiv_sel, muldiv_start;
  logic [1:0] regs_w_data, trap_cause;
  logic       branch, branch_zero, jump, trap;

  logic       n_imem_req, n_ir_write, n_pc_write, n_alu_in1, n_alu_in2;
  logic [3:0] n_alu_op, n_mem_r_enb, n_mem_w_enb;
  logic [2:0] n_imm_op, n_state;
  logic       n_regs_r_enb, n_regs_w_enb, n_muldiv_sel, n_muldiv_start;
  logic [1:0] n_regs_w_data, n_trap_cause;
  logic       n_branch, n_branch_zero, n_jump, n_trap;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(.ENABLE_M(1), .MEM_TIMEOUT(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .funct7_m(funct7_m), .imem_ack(imem_ack), .dmem_ack(dmem_ack), .muldiv_done(muldiv_done),
    .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .alu_op(alu_op),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .imm_op(imm_op), .regs_r_enb(regs_r_enb),
    .regs_w_enb(regs_w_enb), .regs_w_data(regs_w_data), .muldiv_sel(muldiv_sel),
    .muldiv_start(muldiv_start), .mem_r_enb(mem_r_enb), .mem_w_enb(mem_w_enb),
    .branch(branch), .branch_zero(branch_zero), .jump(jump), .trap(trap),
    .trap_cause(trap_cause), .state(state)
  );

  multicycle_control_unit #(.ENABLE_M(0), .MEM_TIMEOUT(16), .CNT_W(8)) n_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .funct7_m(funct7_m), .imem_ack(imem_ack), .dmem_ack(dmem_ack), .muldiv_done(muldiv_done),
    .imem_req(n_imem_req), .ir_write(n_ir_write), .pc_write(n_pc_write), .alu_op(n_alu_op),
    .alu_in1(n_alu_in1), .alu_in2(n_alu_in2), .imm_op(n_imm_op), .regs_r_enb(n_regs_r_enb),
    .regs_w_enb(n_regs_w_enb), .regs_w_data(n_regs_w_data), .muldiv_sel(n_muldiv_sel),
    .muldiv_start(n_muldiv_start), .mem_r_enb(n_mem_r_enb), .mem_w_enb(n_mem_w_enb),
    .branch(n_branch), .branch_zero(n_branch_zero), .jump(n_jump), .trap(n_trap),
    .trap_cause(n_trap_cause), .state(n_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_ir(input logic [31:0] ir);
    opcode   = ir[6:0];
    funct3   = ir[14:12];
    funct7   = ir[30];
    funct7_m = ir[25];
  endtask

  // Move to mid-cycle of the next clock and drop all acks to their idle level.
  task automatic tick();
    @(negedge clk);
    imem_ack    = 1'b0;
    dmem_ack    = 1'b0;
    muldiv_done = 1'b0;
  endtask

  // Called mid-FETCH: present the instruction with an immediate imem_ack.
  task automatic do_fetch(input logic [31:0] ir, input string tag);
    set_ir(ir);
    imem_ack = 1'b1;
    #1;
    check({tag, "_fetch_state"}, state, 0);
    check({tag, "_fetch_irw"}, ir_write, 1);
    check({tag, "_fetch_req"}, imem_req, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
  endtask

  logic [2:0] br_f3  [5] = '{3'b001, 3'b100, 3'b110, 3'b101, 3'b000};
  logic [3:0] br_alu [5] = '{4'b0100, 4'b0010, 4'b0011, 4'b0010, 4'b0100};
  logic       br_bz  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int starts;
    rst = 1'b1; opcode = '0; funct3 = '0; funct7 = 1'b0; funct7_m = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0; muldiv_done = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_state", state, 0);
    check("rst_imem_req", imem_req, 1);
    check("rst_trap", {trap_cause, trap}, 0);
    check("rst_ir_write", ir_write, 0);
    check("rst_pc_write", pc_write, 0);
    @(negedge clk);
    rst = 1'b0;

    // ADDI x1, x0, 5
    do_fetch(32'h00500093, "addi");
    tick(); #1;
    check("addi_dec_state", state, 1);
    check("addi_dec_rd", regs_r_enb, 1);
    check("addi_dec_irw", ir_write, 0);
    tick(); #1;
    check("addi_ex_state", state, 2);
    check("addi_ex_in2", alu_in2, 1);
    check("addi_ex_imm", imm_op, 1);
    check("addi_ex_alu", alu_op, 0);
    check("addi_ex_pcw", pc_write, 0);
    tick(); #1;
    check("addi_wb_state", state, 4);
    check("addi_wb_we", regs_w_enb, 1);
    check("addi_wb_pcw", pc_write, 1);
    check("addi_wb_src", regs_w_data, 0);
    tick(); #1;
    check("addi_done_state", state, 0);

    // SRAI keeps IR[30] in alu_op
    do_fetch(32'h4010D093, "srai");
    tick(); tick(); #1;
    check("srai_ex_alu", alu_op, 4'b1101);
    tick(); tick();

    // LW with ack on the fourth MEM cycle
    do_fetch(32'h00002083, "lw");
    tick(); tick(); #1;
    check("lw_ex_state", state, 2);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) dmem_ack = 1'b1;
      #1;
      check($sformatf("lw_mem%0d_state", i), state, 3);
      check($sformatf("lw_mem%0d_ren", i), mem_r_enb, 4'b1111);
      check($sformatf("lw_mem%0d_wen", i), mem_w_enb, 0);
    end
    tick(); #1;
    check("lw_wb_state", state, 4);
    check("lw_wb_src", regs_w_data, 1);
    check("lw_wb_we", regs_w_enb, 1);
    tick(); #1;
    check("lw_done_state", state, 0);

    // SB with immediate ack
    do_fetch(32'h00100023, "sb");
    tick(); tick(); #1;
    check("sb_ex_imm", imm_op, 2);
    tick(); dmem_ack = 1'b1; #1;
    check("sb_mem_state", state, 3);
    check("sb_mem_wen", mem_w_enb, 4'b0001);
    check("sb_mem_ren", mem_r_enb, 0);
    check("sb_mem_pcw", pc_write, 1);
    tick(); #1;
    check("sb_done_state", state, 0);
    check("sb_done_we", regs_w_enb, 0);

    // Branch family
    for (int i = 0; i < 5; i++) begin
      do_fetch(32'h00100063 | {17'd0, br_f3[i], 12'd0}, "br");
      tick(); #1;
      check($sformatf("br%0d_dec_rd", i), regs_r_enb, 1);
      tick(); #1;
      check($sformatf("br%0d_state", i), state, 2);
      check($sformatf("br%0d_alu", i), alu_op, br_alu[i]);
      check($sformatf("br%0d_branch", i), branch, 1);
      check($sformatf("br%0d_bz", i), branch_zero, br_bz[i]);
      check($sformatf("br%0d_pcw", i), pc_write, 1);
      check($sformatf("br%0d_we", i), regs_w_enb, 0);
      check($sformatf("br%0d_imm", i), imm_op, 3);
      tick(); #1;
      check($sformatf("br%0d_next", i), state, 0);
    end

    // JAL
    do_fetch(32'h008000EF, "jal");
    tick(); #1;
    check("jal_dec_rd", regs_r_enb, 0);
    tick(); #1;
    check("jal_ex_in1", alu_in1, 1);
    check("jal_ex_imm", imm_op, 5);
    tick(); #1;
    check("jal_wb_state", state, 4);
    check("jal_wb_jump", jump, 1);
    check("jal_wb_src", regs_w_data, 2);
    check("jal_wb_pcw", pc_write, 1);
    tick();

    // LUI
    do_fetch(32'h123450B7, "lui");
    tick(); #1;
    check("lui_dec_rd", regs_r_enb, 0);
    tick(); tick(); #1;
    check("lui_wb_src", regs_w_data, 3);
    tick();

    // LW with no ack: timeout trap after 16 MEM cycles
    do_fetch(32'h00002083, "lwto");
    tick(); tick();
    for (int i = 0; i < 16; i++) begin
      tick(); #1;
      check($sformatf("lwto_mem%0d_state", i), state, 3);
    end
    tick(); #1;
    check("lwto_state", state, 5);
    check("lwto_trap", trap, 1);
    check("lwto_cause", trap_cause, 2);
    check("lwto_ren", mem_r_enb, 0);
    check("lwto_req", imem_req, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      imem_ack = 1'b1; dmem_ack = 1'b1; muldiv_done = 1'b1;
      #1;
      check($sformatf("trap_hold%0d_state", i), state, 5);
      check($sformatf("trap_hold%0d_irw", i), ir_write, 0);
      check($sformatf("trap_hold%0d_pcw", i), pc_write, 0);
    end
    do_reset(); #1;
    check("post_trap_rst", {trap_cause, trap}, 0);

    // Illegal opcode 0x7F
    do_fetch(32'h0000007F, "ill");
    tick(); #1;
    check("ill_dec_state", state, 1);
    check("ill_dec_rd", regs_r_enb, 0);
    tick(); #1;
    check("ill_state", state, 5);
    check("ill_trap", trap, 1);
    check("ill_cause", trap_cause, 1);
    do_reset();

    // MUL: illegal without M, handshake with M
    do_fetch(32'h023100B3, "mul");
    tick(); tick(); #1;
    check("mul_nom_state", n_state, 5);
    check("mul_nom_cause", n_trap_cause, 1);
    check("mul_ex_state", state, 2);
    check("mul_ex_start", muldiv_start, 1);
    starts = int'(muldiv_start);
    for (int i = 2; i <= 5; i++) begin
      tick();
      if (i == 5) muldiv_done = 1'b1;
      #1;
      check($sformatf("mul_ex%0d_state", i), state, 2);
      starts += int'(muldiv_start);
    end
    check("mul_starts", starts, 1);
    tick(); #1;
    check("mul_wb_state", state, 4);
    check("mul_wb_sel", muldiv_sel, 1);
    check("mul_wb_we", regs_w_enb, 1);
    check("mul_wb_src", regs_w_data, 0);
    tick(); #1;
    check("mul_done_state", state, 0);
    do_reset();

    // Reset mid-MEM of SW
    do_fetch(32'h00102023, "sw");
    tick(); tick(); tick(); #1;
    check("sw_mem_state", state, 3);
    check("sw_mem_wen", mem_w_enb, 4'b1111);
    rst = 1'b1;
    #1;
    check("sw_rst_wen", mem_w_enb, 0);
    check("sw_rst_state", state, 0);
    check("sw_rst_req", imem_req, 1);
    tick();
    rst = 1'b0;
    tick(); #1;
    check("sw_after_state", state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
